// File: rtl/wb_port_scheduler_if.sv
// wb_port_scheduler_if -- bundle of the ALU-result, load-data and
// register-file write-port signals around wb_port_scheduler.
//   alu_valid/alu_ready/alu_rd/alu_result : ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data   : load data handshake (unbuffered)
//   reg_write/write_rd/write_data         : registered register-file write
//   alu_stall                             : ALU FIFO full indication
// master = issuing side (drives valids/payloads), slave = the scheduler.
interface wb_port_scheduler_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_result;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        reg_write;
  logic [4:0]  write_rd;
  logic [63:0] write_data;
  logic        alu_stall;

  modport master (
    output alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, reg_write, write_rd, write_data, alu_stall
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, reg_write, write_rd, write_data, alu_stall
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler -- shares one register-file write port between the ALU
// result path (buffered in an ALU_DEPTH-entry FIFO) and the load path
// (unbuffered). Loads normally win; after STARVE_LIMIT consecutive load grants
// with ALU entries waiting, one cycle is reserved for the FIFO head.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : wb_port_scheduler_if.slave (handshakes and write port)
module wb_port_scheduler #(
  parameter int ALU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_port_scheduler_if.slave   bus
);

  localparam int PTR_W = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;
  localparam int CNT_W = $clog2(ALU_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(ALU_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  typedef enum logic {NORMAL, ALU_PRIO} state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           fifo_mem [ALU_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [STV_W-1:0] starve_q, starve_d;

  logic   empty, full;
  logic   alu_fire, mem_fire;
  logic   grant, enq, deq;
  entry_t grant_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // Grant selection, handshake outputs and next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    starve_d      = starve_q;
    grant         = 1'b0;
    enq           = 1'b0;
    deq           = 1'b0;
    grant_entry   = '{rd: bus.mem_rd, data: bus.mem_data};
    bus.alu_ready = 1'b0;
    bus.mem_ready = 1'b0;
    bus.alu_stall = 1'b0;

    // Handshakes are closed while reset is asserted so in-flight inputs drop.
    if (rst_n) begin
      bus.alu_ready = !full;
      bus.alu_stall = full;
      bus.mem_ready = (state_q == NORMAL);
    end

    alu_fire = bus.alu_valid && bus.alu_ready;
    mem_fire = bus.mem_valid && bus.mem_ready;

    if (mem_fire) begin
      grant    = 1'b1;
      enq      = alu_fire;
      // Only loads that overtake waiting ALU entries count as starvation.
      starve_d = empty ? '0 : starve_q + STV_W'(1);
    end else if (!empty) begin
      grant       = 1'b1;
      deq         = 1'b1;
      enq         = alu_fire;
      grant_entry = fifo_mem[rd_ptr_q];
      starve_d    = '0;
    end else if (alu_fire) begin
      // Empty FIFO: the offered result goes straight to the port.
      grant       = 1'b1;
      grant_entry = '{rd: bus.alu_rd, data: bus.alu_result};
      starve_d    = '0;
    end else begin
      starve_d = '0;
    end

    // ALU_PRIO always lasts exactly one cycle: mem_ready is low there, so the
    // FIFO head is the one granted.
    if (state_q == ALU_PRIO) begin
      state_d = NORMAL;
    end else if (starve_d == LIMIT_C) begin
      state_d = ALU_PRIO;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q       <= '0;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      bus.reg_write  <= 1'b0;
      bus.write_rd   <= '0;
      bus.write_data <= '0;
    end else begin
      starve_q <= starve_d;
      count_q  <= count_q + CNT_W'(enq) - CNT_W'(deq);
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // x0 is hardwired zero: consume the entry but suppress the write.
      bus.reg_write <= grant && (grant_entry.rd != '0);
      if (grant) begin
        bus.write_rd   <= grant_entry.rd;
        bus.write_data <= grant_entry.data;
      end
    end
  end

  // NOTE: FIFO storage is not reset; count and pointers define validity, so
  // stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr_q] <= '{rd: bus.alu_rd, data: bus.alu_result};
  end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// tb_wb_port_scheduler -- self-checking bench for wb_port_scheduler.
// A queue-based reference model predicts handshakes and write-port outputs
// every cycle; directed sequences cover bypass, conflict, starvation, full
// FIFO, x0 and mid-operation reset, followed by randomized traffic.
module tb_wb_port_scheduler;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  logic clk;
  logic rst_n;
  wb_port_scheduler_if bus();

  wb_port_scheduler #(.ALU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  ent_t        q[$];
  bit          prio;
  int          starve;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [63:0] m_data;

  // Handshake values observed in the most recent cycle.
  logic obs_ar, obs_mr;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check handshakes mid-cycle, advance the
  // model, then check registered outputs just after the rising edge.
  task automatic cycle(input logic rst, input logic av, input logic [4:0] ar,
                       input logic [63:0] ad, input logic mv,
                       input logic [4:0] mr, input logic [63:0] md);
    logic exp_ar, exp_mr, afire, mfire, g, byp;
    ent_t ge;
    int   had;
    rst_n          = rst;
    bus.alu_valid  = av;
    bus.alu_rd     = ar;
    bus.alu_result = ad;
    bus.mem_valid  = mv;
    bus.mem_rd     = mr;
    bus.mem_data   = md;
    #4;
    exp_ar = rst && (q.size() < DEPTH);
    exp_mr = rst && !prio;
    obs_ar = bus.alu_ready;
    obs_mr = bus.mem_ready;
    check("alu_ready", obs_ar, exp_ar);
    check("mem_ready", obs_mr, exp_mr);
    check("alu_stall", bus.alu_stall, rst && (q.size() >= DEPTH));
    g   = 1'b0;
    byp = 1'b0;
    ge  = '{rd: 5'd0, data: 64'd0};
    if (!rst) begin
      q.delete();
      prio   = 1'b0;
      starve = 0;
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
    end else begin
      afire = av && exp_ar;
      mfire = mv && exp_mr;
      had   = q.size();
      if (mfire) begin
        g = 1'b1; ge = '{rd: mr, data: md};
        starve = (had > 0) ? starve + 1 : 0;
      end else if (had > 0) begin
        g = 1'b1; ge = q.pop_front(); starve = 0;
      end else if (afire) begin
        g = 1'b1; byp = 1'b1; ge = '{rd: ar, data: ad}; starve = 0;
      end else begin
        starve = 0;
      end
      if (afire && !byp) q.push_back('{rd: ar, data: ad});
      if (prio) prio = 1'b0;
      else if (starve == LIMIT) prio = 1'b1;
      m_we = g && (ge.rd != 5'd0);
      if (g) begin
        m_rd   = ge.rd;
        m_data = ge.data;
      end
    end
    @(posedge clk);
    #1;
    check("reg_write", bus.reg_write, m_we);
    check("write_rd", bus.write_rd, m_rd);
    check("write_data", bus.write_data, m_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  initial begin
    int k;
    prio   = 1'b0;
    starve = 0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;

    // Reset state.
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 5'd1, 64'd1, 1'b1, 5'd2, 64'd2);
    check("rst_we", bus.reg_write, 1'b0);
    check("rst_rd", bus.write_rd, 5'd0);
    check("rst_data", bus.write_data, 64'd0);

    // Bypass on empty FIFO, no replay afterwards.
    cycle(1'b1, 1'b1, 5'd5, 64'h11, 1'b0, 5'd0, 64'd0);
    check("byp_we", bus.reg_write, 1'b1);
    check("byp_rd", bus.write_rd, 5'd5);
    check("byp_data", bus.write_data, 64'h11);
    idle(1);
    check("byp_noreplay", bus.reg_write, 1'b0);
    check("byp_hold", bus.write_data, 64'h11);

    // Conflict: load first, then the queued ALU result.
    cycle(1'b1, 1'b1, 5'd3, 64'hAA, 1'b1, 5'd4, 64'hBB);
    check("conf_rd1", bus.write_rd, 5'd4);
    check("conf_data1", bus.write_data, 64'hBB);
    idle(1);
    check("conf_rd2", bus.write_rd, 5'd3);
    check("conf_data2", bus.write_data, 64'hAA);
    idle(1);

    // x0 load: consumed, no write.
    cycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF);
    check("x0_mr", obs_mr, 1'b1);
    check("x0_we", bus.reg_write, 1'b0);
    check("x0_rd", bus.write_rd, 5'd0);
    check("x0_data", bus.write_data, 64'hFF);

    // Starvation: entry queued behind a load, then four overtaking loads.
    cycle(1'b1, 1'b1, 5'd7, 64'h77, 1'b1, 5'd8, 64'h80);
    for (int i = 0; i < LIMIT; i++) begin
      cycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'(9 + i), 64'(i));
      check("starve_load", bus.write_rd, 5'(9 + i));
    end
    cycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd20, 64'h20);
    check("starve_mr", obs_mr, 1'b0);
    check("starve_rd", bus.write_rd, 5'd7);
    check("starve_data", bus.write_data, 64'h77);
    cycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd20, 64'h20);
    check("resume_mr", obs_mr, 1'b1);
    check("resume_rd", bus.write_rd, 5'd20);
    idle(2);

    // Full FIFO: three results against continuous loads.
    k = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 5'(21 + k), 64'(16'hC0 + k), 1'b1, 5'd30, 64'(i));
      if (obs_ar) k++;
    end
    check("full_count", k, 2);
    check("full_stall", obs_ar, 1'b0);
    for (int i = 0; i < 20 && k < 3; i++) begin
      cycle(1'b1, 1'b1, 5'(21 + k), 64'(16'hC0 + k), 1'b1, 5'd30, 64'(i));
      if (obs_ar) k++;
    end
    check("full_done", k, 3);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd30, 64'd5);
    idle(3);

    // Reset with two queued entries: they must never be written.
    cycle(1'b1, 1'b1, 5'd9, 64'h99, 1'b1, 5'd1, 64'h1);
    cycle(1'b1, 1'b1, 5'd10, 64'hA0, 1'b1, 5'd2, 64'h2);
    cycle(1'b0, 1'b1, 5'd11, 64'hB0, 1'b1, 5'd3, 64'h3);
    check("mrst_we", bus.reg_write, 1'b0);
    check("mrst_rd", bus.write_rd, 5'd0);
    check("mrst_data", bus.write_data, 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("mrst_nowrite", bus.reg_write, 1'b0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      logic r;
      r = ($urandom_range(63) != 0);
      cycle(r, 1'($urandom_range(99) < 60), 5'($urandom_range(31)),
            {$urandom, $urandom}, 1'($urandom_range(99) < 55),
            5'($urandom_range(31)), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_scheduler.md
WB_PORT_SCHEDULER -- requirements
Module: wb_port_scheduler

Interface
REQ-001 Parameter ALU_DEPTH, default 2: number of ALU-result FIFO entries (power of two, ≥2).
REQ-002 Parameter STARVE_LIMIT, default 4: maximum consecutive memory grants while ALU entries wait.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 alu_valid  input  1  ALU result offered this cycle.
REQ-006 alu_ready  output  1  ALU result accepted when alu_valid && alu_ready.
REQ-007 alu_rd  input  5  ALU destination register.
REQ-008 alu_result  input  64  ALU result data.
REQ-009 mem_valid  input  1  load data offered this cycle.
REQ-010 mem_ready  output  1  load accepted when mem_valid && mem_ready.
REQ-011 mem_rd  input  5  load destination register.
REQ-012 mem_data  input  64  load data.
REQ-013 reg_write  output  1  registered register-file write enable.
REQ-014 write_rd  output  5  registered register-file write address.
REQ-015 write_data  output  64  registered register-file write data.
REQ-016 alu_stall  output  1  high when ALU FIFO is full (= !alu_ready outside reset).

Function
REQ-017 The block SHALL share the single register-file write port between the ALU and memory paths; exactly one source is granted per cycle at most.
REQ-018 The block SHALL hold ALU results in an ALU_DEPTH-entry FIFO; alu_ready = (count < ALU_DEPTH); loads are not buffered.
REQ-019 States: NORMAL, ALU_PRIO; mem_ready SHALL be 1 in NORMAL and 0 in ALU_PRIO.
REQ-020 In NORMAL, a valid load SHALL win the port; otherwise the ALU source wins.
REQ-021 ALU source SHALL be the FIFO head when count > 0; when count == 0, an accepted alu_valid SHALL bypass the FIFO and be granted in the same cycle (not enqueued).
REQ-022 Enqueue and dequeue in the same cycle SHALL leave count unchanged; FIFO order SHALL be strict FIFO with wrap-around pointers.
REQ-023 Starvation counter SHALL increment on each cycle a load is granted while count > 0, and clear on any ALU grant or when count == 0.
REQ-024 When the counter reaches STARVE_LIMIT, state SHALL move to ALU_PRIO next cycle; in ALU_PRIO exactly one FIFO entry is granted, counter clears, and state returns to NORMAL next cycle.
REQ-025 Latency: a granted source SHALL appear on reg_write/write_rd/write_data at the next rising edge (1 cycle).
REQ-026 No grant in a cycle SHALL give reg_write = 0 next cycle; write_rd/write_data SHALL hold previous values.
REQ-027 A granted entry with rd == 0 SHALL be consumed normally but produce reg_write = 0 (x0 never written); write_rd/write_data still update.
REQ-028 Same-rd ordering between ALU and load paths is the issuing stage's responsibility; this block SHALL NOT reorder within the ALU path.

Reset
REQ-029 While rst_n is low at a rising edge: state = NORMAL, counter = 0, FIFO count and pointers = 0 (contents discarded), reg_write = 0, write_rd = 0, write_data = 0.
REQ-030 While rst_n is low, alu_ready and mem_ready SHALL be 0 and alu_stall SHALL be 0; in-flight inputs during reset are dropped.
REQ-031 First grant after reset release SHALL follow REQ-020/021 with empty FIFO and counter 0.

Verification
REQ-032 Bypass: empty FIFO, alu_valid=1, alu_rd=5, alu_result=0x11 -> next cycle reg_write=1, write_rd=5, write_data=0x11; count stays 0.
REQ-033 Conflict: alu (rd=3, 0xAA) and mem (rd=4, 0xBB) same cycle -> cycle+1 writes rd=4/0xBB, cycle+2 writes rd=3/0xAA.
REQ-034 Starvation: mem_valid held 1 continuously, one ALU entry queued, STARVE_LIMIT=4 -> four load writes, then mem_ready=0 one cycle, ALU entry written, loads resume.
REQ-035 Full: three ALU results, mem_valid held 1 -> alu_ready/alu_stall flips after 2 enqueues, third held until a slot frees; no entry lost or duplicated.
REQ-036 x0: mem rd=0, data 0xFF -> next cycle reg_write=0, write_rd=0, mem_ready was 1.
REQ-037 Reset mid-operation: FIFO holding 2 entries, rst_n=0 one edge -> all outputs 0, count 0, queued entries never written after release.
